// File: rtl/wb_text_console_if.sv
// Byte-stream input and Wishbone write-master bundle for wb_text_console.
interface wb_text_console_if;
  logic [7:0] I_rx_data;
  logic       I_rx_valid;
  logic       O_rx_ready;
  logic [7:0] O_wbm_adr;
  logic [7:0] O_wbm_dat;
  logic       O_wbm_we;
  logic       O_wbm_stb;
  logic       O_wbm_cyc;
  logic       I_wbm_ack;

  modport master (
    input  I_rx_data, I_rx_valid, I_wbm_ack,
    output O_rx_ready, O_wbm_adr, O_wbm_dat, O_wbm_we, O_wbm_stb, O_wbm_cyc
  );

  modport slave (
    output I_rx_data, I_rx_valid, I_wbm_ack,
    input  O_rx_ready, O_wbm_adr, O_wbm_dat, O_wbm_we, O_wbm_stb, O_wbm_cyc
  );
endinterface

// File: rtl/wb_text_console.sv
// Terminal engine: byte stream in, Wishbone register writes to the text generator out.
// Optional: define WB_TEXT_CONSOLE_ESC_EN to make ESC <b> load the attribute register.
module wb_text_console #(
  parameter int         COLS         = 80,
  parameter int         ROWS         = 26,
  parameter int         TAB_W        = 8,
  parameter logic [7:0] DEFAULT_ATTR = 8'h0F,
  parameter int         ACK_TIMEOUT  = 4095
) (
  input  logic                I_wb_clk,
  input  logic                I_wb_rst,
  wb_text_console_if.master   bus,
  output logic                O_busy,
  output logic                O_err
);

  localparam logic [2:0] ST_INIT   = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_DEC    = 3'd2;
  localparam logic [2:0] ST_LAUNCH = 3'd3;
  localparam logic [2:0] ST_WAIT   = 3'd4;
  localparam logic [2:0] ST_NEXT   = 3'd5;

  localparam logic [3:0] OP_INITATTR = 4'd0;
  localparam logic [3:0] OP_CLR      = 4'd1;
  localparam logic [3:0] OP_COL      = 4'd2;
  localparam logic [3:0] OP_ROW      = 4'd3;
  localparam logic [3:0] OP_CHR      = 4'd4;
  localparam logic [3:0] OP_BASEH1   = 4'd5;
  localparam logic [3:0] OP_BASEL1   = 4'd6;
  localparam logic [3:0] OP_FILL     = 4'd7;
  localparam logic [3:0] OP_BASEH2   = 4'd8;
  localparam logic [3:0] OP_BASEL2   = 4'd9;
  localparam logic [3:0] OP_ATTRF    = 4'd10;
  localparam logic [3:0] OP_SETATTR  = 4'd11;

  localparam logic [6:0] COL_LAST = 7'(COLS - 1);
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);
  localparam int         TMO_W    = $clog2(ACK_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  logic [2:0]       st;
  logic [3:0]       op;
  logic [6:0]       col, wr_col, clr_cnt;
  logic [4:0]       row, wr_row;
  logic [7:0]       chr;
  logic [11:0]      base;
  logic             nl_pend;
  logic [7:0]       cur_attr;
  logic [TMO_W-1:0] tmo_cnt;
`ifdef WB_TEXT_CONSOLE_ESC_EN
  logic             esc_armed;
`endif

  logic [7:0] op_adr, op_dat;
  logic [3:0] op_nxt;
  logic       op_done;

  function automatic logic [6:0] tab_stop(input logic [6:0] c);
    logic [7:0] t;
    t = {1'b0, c | 7'(TAB_W - 1)} + 8'd1;
    return (t > {1'b0, COL_LAST}) ? COL_LAST : t[6:0];
  endfunction

  function automatic logic [4:0] row_inc(input logic [4:0] r);
    return (r == ROW_LAST) ? 5'd0 : r + 5'd1;
  endfunction

  function automatic logic [11:0] row_base(input logic [4:0] r);
    return 12'(r) * 12'(COLS);
  endfunction

  function automatic logic is_print(input logic [7:0] b);
    return (b >= 8'h20) && (b != 8'h7F);
  endfunction

  assign bus.O_rx_ready = (st == ST_IDLE);
  assign O_busy         = (st != ST_IDLE);

  always_comb begin
    op_adr  = 8'h00;
    op_dat  = 8'h00;
    op_nxt  = op;
    op_done = 1'b0;
    case (op)
      OP_INITATTR: begin op_adr = 8'h03; op_dat = DEFAULT_ATTR;           op_nxt = OP_CLR; end
      OP_CLR:      begin op_adr = 8'h0A;                                   op_done = 1'b1; end
      OP_COL:      begin op_adr = 8'h01; op_dat = {1'b0, wr_col};          op_nxt = OP_ROW; end
      OP_ROW:      begin op_adr = 8'h02; op_dat = {3'b000, wr_row};        op_nxt = OP_CHR; end
      OP_CHR: begin
        op_adr = 8'h04; op_dat = chr;
        op_nxt = OP_BASEH1; op_done = !nl_pend;
      end
      OP_BASEH1:   begin op_adr = 8'h06; op_dat = {4'h0, base[11:8]};     op_nxt = OP_BASEL1; end
      OP_BASEL1:   begin op_adr = 8'h07; op_dat = base[7:0];              op_nxt = OP_FILL; end
      OP_FILL: begin
        op_adr = 8'h08; op_dat = 8'h20;
        op_nxt = (clr_cnt == COL_LAST) ? OP_BASEH2 : OP_FILL;
      end
      OP_BASEH2:   begin op_adr = 8'h06; op_dat = {4'h0, base[11:8]};     op_nxt = OP_BASEL2; end
      OP_BASEL2:   begin op_adr = 8'h07; op_dat = base[7:0];              op_nxt = OP_ATTRF; end
      OP_ATTRF: begin
        op_adr = 8'h09; op_dat = cur_attr;
        op_done = (clr_cnt == COL_LAST);
      end
      OP_SETATTR:  begin op_adr = 8'h03; op_dat = cur_attr;               op_done = 1'b1; end
      default:     op_done = 1'b1;
    endcase
  end

  always_ff @(posedge I_wb_clk or posedge I_wb_rst) begin
    if (I_wb_rst) begin
      st            <= ST_INIT;
      op            <= OP_INITATTR;
      col           <= 7'd0;
      row           <= 5'd0;
      wr_col        <= 7'd0;
      wr_row        <= 5'd0;
      clr_cnt       <= 7'd0;
      chr           <= 8'h00;
      base          <= 12'd0;
      nl_pend       <= 1'b0;
      cur_attr      <= DEFAULT_ATTR;
      tmo_cnt       <= '0;
      O_err         <= 1'b0;
      bus.O_wbm_cyc <= 1'b0;
      bus.O_wbm_stb <= 1'b0;
      bus.O_wbm_we  <= 1'b0;
      bus.O_wbm_adr <= 8'h00;
      bus.O_wbm_dat <= 8'h00;
`ifdef WB_TEXT_CONSOLE_ESC_EN
      esc_armed     <= 1'b0;
`endif
    end else begin
      case (st)
        ST_INIT: begin
          op <= OP_INITATTR;
          st <= ST_LAUNCH;
        end
        ST_IDLE: begin
          if (bus.I_rx_valid) begin
            chr <= bus.I_rx_data;
            st  <= ST_DEC;
          end
        end
        ST_DEC: begin
          st <= ST_IDLE;
`ifdef WB_TEXT_CONSOLE_ESC_EN
          if (esc_armed) begin
            esc_armed <= 1'b0;
            cur_attr  <= chr;
            op        <= OP_SETATTR;
            st        <= ST_LAUNCH;
          end else
`endif
          begin
            case (chr)
              8'h0D: col <= 7'd0;
              8'h08: if (col != 7'd0) col <= col - 7'd1;
              8'h09: col <= tab_stop(col);
              8'h0A: begin
                row     <= row_inc(row);
                base    <= row_base(row_inc(row));
                clr_cnt <= 7'd0;
                op      <= OP_BASEH1;
                st      <= ST_LAUNCH;
              end
              8'h0C: begin
                col <= 7'd0;
                row <= 5'd0;
                op  <= OP_CLR;
                st  <= ST_LAUNCH;
              end
`ifdef WB_TEXT_CONSOLE_ESC_EN
              8'h1B: esc_armed <= 1'b1;
`endif
              default: begin
                if (is_print(chr)) begin
                  // Cursor advances now; the three writes use the snapshot
                  wr_col  <= col;
                  wr_row  <= row;
                  clr_cnt <= 7'd0;
                  op      <= OP_COL;
                  st      <= ST_LAUNCH;
                  if (col == COL_LAST) begin
                    col     <= 7'd0;
                    row     <= row_inc(row);
                    base    <= row_base(row_inc(row));
                    nl_pend <= 1'b1;
                  end else begin
                    col     <= col + 7'd1;
                    nl_pend <= 1'b0;
                  end
                end
              end
            endcase
          end
        end
        ST_LAUNCH: begin
          bus.O_wbm_cyc <= 1'b1;
          bus.O_wbm_stb <= 1'b1;
          bus.O_wbm_we  <= 1'b1;
          bus.O_wbm_adr <= op_adr;
          bus.O_wbm_dat <= op_dat;
          tmo_cnt       <= '0;
          st            <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.I_wbm_ack || (tmo_cnt == TMO_LAST)) begin
            bus.O_wbm_cyc <= 1'b0;
            bus.O_wbm_stb <= 1'b0;
            bus.O_wbm_we  <= 1'b0;
            bus.O_wbm_adr <= 8'h00;
            bus.O_wbm_dat <= 8'h00;
            if (bus.I_wbm_ack) begin
              st <= ST_NEXT;
            end else begin
              O_err <= 1'b1;
              st    <= ST_IDLE;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_NEXT: begin
          // This cycle also guarantees stb low between transactions
          if (op_done) begin
            st <= ST_IDLE;
          end else begin
            clr_cnt <= (op_nxt == op) ? clr_cnt + 7'd1 : 7'd0;
            op      <= op_nxt;
            st      <= ST_LAUNCH;
          end
        end
        default: st <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_text_console.sv
// Directed bench for wb_text_console: vector table plus row-clear, wrap, timeout and reset sequences.
module tb_wb_text_console;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, err;
  logic ack_en = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   gap_bad = 0;
  logic prev_ack_edge = 1'b0;
  logic [15:0] wr_q[$];

`ifdef WB_TEXT_CONSOLE_ESC_EN
  localparam logic [7:0] EXP_ATTR = 8'h1E;
`else
  localparam logic [7:0] EXP_ATTR = 8'h0F;
`endif

  wb_text_console_if bus();

  wb_text_console dut (
    .I_wb_clk (clk),
    .I_wb_rst (rst),
    .bus      (bus),
    .O_busy   (busy),
    .O_err    (err)
  );

  always #5 clk = ~clk;

  // Registered-ack slave with write logger and inter-transaction gap monitor
  always @(posedge clk) begin
    if (prev_ack_edge && bus.O_wbm_stb) gap_bad++;
    prev_ack_edge <= bus.O_wbm_cyc && bus.O_wbm_stb && bus.I_wbm_ack;
    if (bus.O_wbm_cyc && bus.O_wbm_stb && bus.I_wbm_ack)
      wr_q.push_back({bus.O_wbm_adr, bus.O_wbm_dat});
    bus.I_wbm_ack <= ack_en && bus.O_wbm_cyc && bus.O_wbm_stb && !bus.I_wbm_ack;
  end

  typedef struct {
    logic [7:0]  b;
    int          nwr;
    logic [15:0] last;
    logic [6:0]  col;
    logic [4:0]  row;
  } vec_t;

  vec_t vt[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!bus.O_rx_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.O_rx_ready) chk("rx_ready_wait", 32'd0, 32'd1);
    bus.I_rx_data  = b;
    bus.I_rx_valid = 1'b1;
    @(posedge clk);
    #1 bus.I_rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_wait", 32'd1, 32'd0);
  endtask

  task automatic put(input logic [7:0] b);
    send_byte(b);
    wait_idle();
  endtask

  initial begin
    int n;
    bus.I_rx_data  = 8'h00;
    bus.I_rx_valid = 1'b0;
    bus.I_wbm_ack  = 1'b0;

    vt[0]  = '{8'h41, 3,   16'h0441, 7'd1,  5'd0};
    vt[1]  = '{8'h0D, 0,   16'h0000, 7'd0,  5'd0};
    vt[2]  = '{8'h08, 0,   16'h0000, 7'd0,  5'd0};
    vt[3]  = '{8'h62, 3,   16'h0462, 7'd1,  5'd0};
    vt[4]  = '{8'h63, 3,   16'h0463, 7'd2,  5'd0};
    vt[5]  = '{8'h64, 3,   16'h0464, 7'd3,  5'd0};
    vt[6]  = '{8'h09, 0,   16'h0000, 7'd8,  5'd0};
    vt[7]  = '{8'h09, 0,   16'h0000, 7'd16, 5'd0};
    vt[8]  = '{8'h08, 0,   16'h0000, 7'd15, 5'd0};
    vt[9]  = '{8'h0A, 164, 16'h090F, 7'd15, 5'd1};
    vt[10] = '{8'h07, 0,   16'h0000, 7'd15, 5'd1};
    vt[11] = '{8'h7F, 0,   16'h0000, 7'd15, 5'd1};
    vt[12] = '{8'h1B, 0,   16'h0000, 7'd15, 5'd1};
`ifdef WB_TEXT_CONSOLE_ESC_EN
    vt[13] = '{8'h1E, 1,   16'h031E, 7'd15, 5'd1};
`else
    vt[13] = '{8'h1E, 0,   16'h0000, 7'd15, 5'd1};
`endif
    vt[14] = '{8'h78, 3,   16'h0478, 7'd16, 5'd1};
    vt[15] = '{8'hC8, 3,   16'h04C8, 7'd17, 5'd1};
    vt[16] = '{8'h0C, 1,   16'h0A00, 7'd0,  5'd0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_stb",   32'(bus.O_wbm_stb),  32'd0);
    chk("rst_cyc",   32'(bus.O_wbm_cyc),  32'd0);
    chk("rst_ready", 32'(bus.O_rx_ready), 32'd0);
    chk("rst_busy",  32'(busy),           32'd1);
    chk("rst_err",   32'(err),            32'd0);

    // Init sequence
    wr_q.delete();
    rst = 1'b0;
    wait_idle();
    chk("init_n",     32'(wr_q.size()),   32'd2);
    chk("init_w0",    32'(wr_q[0]),       32'h030F);
    chk("init_w1",    32'(wr_q[1]),       32'h0A00);
    chk("init_ready", 32'(bus.O_rx_ready), 32'd1);
    chk("init_busy",  32'(busy),          32'd0);

    // Table-driven single-byte vectors
    for (int i = 0; i < 17; i++) begin
      wr_q.delete();
      put(vt[i].b);
      chk($sformatf("v%0d_nwr", i), 32'(wr_q.size()), 32'(vt[i].nwr));
      if (vt[i].nwr > 0)
        chk($sformatf("v%0d_last", i), 32'(wr_q[wr_q.size()-1]), 32'(vt[i].last));
      chk($sformatf("v%0d_col", i), 32'(dut.col), 32'(vt[i].col));
      chk($sformatf("v%0d_row", i), 32'(dut.row), 32'(vt[i].row));
    end

    // Full row then wrap with row clear
    for (int i = 0; i < 79; i++) put(8'h61);
    wr_q.delete();
    put(8'h5A);
    chk("wrap_n",    32'(wr_q.size()), 32'd167);
    chk("wrap_w0",   32'(wr_q[0]),     32'h014F);
    chk("wrap_w2",   32'(wr_q[2]),     32'h045A);
    chk("wrap_w3",   32'(wr_q[3]),     32'h0600);
    chk("wrap_w4",   32'(wr_q[4]),     32'h0750);
    chk("wrap_w5",   32'(wr_q[5]),     32'h0820);
    chk("wrap_w84",  32'(wr_q[84]),    32'h0820);
    chk("wrap_w85",  32'(wr_q[85]),    32'h0600);
    chk("wrap_w86",  32'(wr_q[86]),    32'h0750);
    chk("wrap_w87",  32'(wr_q[87]),    {16'h0, 8'h09, EXP_ATTR});
    chk("wrap_w166", 32'(wr_q[166]),   {16'h0, 8'h09, EXP_ATTR});
    chk("wrap_col",  32'(dut.col),     32'd0);
    chk("wrap_row",  32'(dut.row),     32'd1);
    chk("gap",       32'(gap_bad),     32'd0);

    // Last row and row wrap-around
    for (int i = 0; i < 23; i++) put(8'h0A);
    wr_q.delete();
    put(8'h0A);
    chk("row25",    32'(dut.row), 32'd25);
    chk("row25_w0", 32'(wr_q[0]), 32'h0607);
    chk("row25_w1", 32'(wr_q[1]), 32'h07D0);
    wr_q.delete();
    put(8'h0A);
    chk("row0",     32'(dut.row), 32'd0);
    chk("row0_w0",  32'(wr_q[0]), 32'h0600);
    chk("row0_w1",  32'(wr_q[1]), 32'h0700);
    wr_q.delete();
    put(8'h0D);
    put(8'h08);
    chk("crbs_col", 32'(dut.col),      32'd0);
    chk("crbs_n",   32'(wr_q.size()),  32'd0);

    // Ack timeout
    ack_en = 1'b0;
    send_byte(8'h51);
    n = 0;
    @(negedge clk);
    while (!bus.O_wbm_stb && n < 100) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (bus.O_wbm_stb && n < 6000) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_cycles", 32'(n),             32'd4095);
    chk("tmo_cyc",    32'(bus.O_wbm_cyc), 32'd0);
    chk("tmo_err",    32'(err),           32'd1);
    wait_idle();
    chk("tmo_col",    32'(dut.col),       32'd1);
    ack_en = 1'b1;
    wr_q.delete();
    put(8'h52);
    chk("tmo_after_n", 32'(wr_q.size()), 32'd3);
    chk("tmo_after_w", 32'(wr_q[2]),     32'h0452);
    chk("err_sticky",  32'(err),         32'd1);

    // Reset during a stalled transaction
    ack_en = 1'b0;
    send_byte(8'h4D);
    n = 0;
    @(negedge clk);
    while (!bus.O_wbm_stb && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mid_stb_up", 32'(bus.O_wbm_stb), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_stb", 32'(bus.O_wbm_stb), 32'd0);
    chk("mid_cyc", 32'(bus.O_wbm_cyc), 32'd0);
    repeat (2) @(negedge clk);
    wr_q.delete();
    ack_en = 1'b1;
    rst = 1'b0;
    wait_idle();
    chk("reinit_n",  32'(wr_q.size()), 32'd2);
    chk("reinit_w0", 32'(wr_q[0]),     32'h030F);
    chk("reinit_w1", 32'(wr_q[1]),     32'h0A00);
    chk("reinit_err", 32'(err),        32'd0);
    chk("reinit_col", 32'(dut.col),    32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
